vector_list_sequencer: RTL

// Walks a display list in external synchronous RAM and feeds the vector control block one command at a time.

---
 rtl/vector_list_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vector_list_sequencer.sv
// Display-list walker: fetches JUMP/DRAW/NOP/END words from synchronous RAM and
// hands one beam command at a time to the vector control block, pacing on ready.
module vector_list_sequencer #(
  parameter int ADDR_W        = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              ready,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              jump,
  output logic              draw,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [15:0]       vec_count
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_SETTLE, S_DRAIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_JUMP, OP_DRAW, OP_NOP, OP_END} op_t;

  state_t          state;
  op_t             cmd_op;
  logic [11:0]     cmd_x;
  logic [11:0]     cmd_y;
  logic [SW-1:0]   settle_cnt;
  logic            at_end;
  logic            unused_bits;

  assign at_end      = (mem_addr == '1);
  assign unused_bits = ^mem_data[29:24];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_op     <= OP_JUMP;
      cmd_x      <= '0;
      cmd_y      <= '0;
      settle_cnt <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      x          <= '0;
      y          <= '0;
      jump       <= 1'b0;
      draw       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      vec_count  <= '0;
    end else if (abort && state != S_IDLE) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      mem_rd <= 1'b0;
      jump   <= 1'b0;
      draw   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            mem_addr  <= base_addr;
            vec_count <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            mem_rd    <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_rd <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          cmd_op <= op_t'(mem_data[31:30]);
          cmd_x  <= mem_data[23:12];
          cmd_y  <= mem_data[11:0];
          state  <= S_DECODE;
        end
        S_DECODE: begin
          case (cmd_op)
            OP_END: begin
              done  <= 1'b1;
              state <= S_DONE;
            end
            OP_NOP: begin
              if (at_end) begin
                overrun <= 1'b1;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_rd   <= 1'b1;
                state    <= S_FETCH;
              end
            end
            default: begin
              x     <= cmd_x;
              y     <= cmd_y;
              state <= S_ISSUE;
              // Ready already high: pulse lands in the first ISSUE cycle.
              if (ready) begin
                jump <= (cmd_op == OP_JUMP);
                draw <= (cmd_op == OP_DRAW);
                if (vec_count != '1) vec_count <= vec_count + 16'd1;
              end
            end
          endcase
        end
        S_ISSUE: begin
          if (jump || draw) begin
            jump       <= 1'b0;
            draw       <= 1'b0;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            state      <= S_SETTLE;
          end else if (ready) begin
            jump <= (cmd_op == OP_JUMP);
            draw <= (cmd_op == OP_DRAW);
            if (vec_count != '1) vec_count <= vec_count + 16'd1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_DRAIN;
          else                  settle_cnt <= settle_cnt - SW'(1);
        end
        S_DRAIN: begin
          if (ready) begin
            if (at_end) begin
              overrun <= 1'b1;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              mem_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
